// File: rtl/pc_fetch_unit.sv
// Program counter register and instruction fetch sequencer.
// Selects the next PC, drives the imem req/ack handshake and holds the fetched instruction.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_WRITE,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JAL,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JALR,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] IR,
  output logic        IR_VALID,
  output logic        PC_MISALIGN
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  // Reserved selects 6/7 fall through to sequential flow.
  always_comb begin
    next_pc = pc_plus4;
    case (PC_SOURCE)
      3'd1:    next_pc = JALR;
      3'd2:    next_pc = BRANCH;
      3'd3:    next_pc = JAL;
      3'd4:    next_pc = MTVEC;
      3'd5:    next_pc = MEPC;
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    misalign_d = 1'b0;
    case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        if (IMEM_ACK) begin
          ir_d    = IMEM_DATA;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (PC_WRITE) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = FETCH;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= START;
      pc_q       <= RESET_VEC;
      ir_q       <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      misalign_q <= misalign_d;
    end
  end

  assign PC          = pc_q;
  assign PC_PLUS4    = pc_plus4;
  assign IMEM_ADDR   = pc_q;
  assign IMEM_REQ    = (state_q == FETCH);
  assign IR          = ir_q;
  assign IR_VALID    = (state_q == HOLD);
  assign PC_MISALIGN = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit, booting from RESET_VEC = 32'h100.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PC_WRITE;
  logic [2:0]  PC_SOURCE;
  logic [31:0] JAL, BRANCH, JALR, MTVEC, MEPC;
  logic        IMEM_ACK;
  logic [31:0] IMEM_DATA;
  logic [31:0] PC, PC_PLUS4, IMEM_ADDR, IR;
  logic        IMEM_REQ, IR_VALID, PC_MISALIGN;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  pc_fetch_unit #(.RESET_VEC(32'h0000_0100)) dut (
    .CLK(CLK), .RST(RST), .PC_WRITE(PC_WRITE), .PC_SOURCE(PC_SOURCE),
    .JAL(JAL), .BRANCH(BRANCH), .JALR(JALR), .MTVEC(MTVEC), .MEPC(MEPC),
    .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .PC(PC), .PC_PLUS4(PC_PLUS4), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IR(IR), .IR_VALID(IR_VALID), .PC_MISALIGN(PC_MISALIGN)
  );

  // Drives the control inputs, then advances one rising edge and settles.
  task automatic applyStimulus(input logic rst, input logic wr, input logic [2:0] src,
                               input logic ack, input logic [31:0] data);
    RST       = rst;
    PC_WRITE  = wr;
    PC_SOURCE = src;
    IMEM_ACK  = ack;
    IMEM_DATA = data;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Load a new PC from HOLD, check the fetch starts, then complete it with zero wait.
  task automatic jumpAndFetch(input string tag, input logic [2:0] src, input logic [31:0] exp_pc);
    applyStimulus(1'b0, 1'b1, src, 1'b0, 32'h0);
    checkOutput({tag, "_pc"}, PC, exp_pc);
    checkOutput({tag, "_irv"}, {31'b0, IR_VALID}, 32'd0);
    checkOutput({tag, "_req"}, {31'b0, IMEM_REQ}, 32'd1);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, exp_pc ^ 32'h0000_0013);
    checkOutput({tag, "_ir"}, IR, exp_pc ^ 32'h0000_0013);
    checkOutput({tag, "_irv2"}, {31'b0, IR_VALID}, 32'd1);
  endtask

  initial begin
    JAL = 32'h400; BRANCH = 32'h300; JALR = 32'h200; MTVEC = 32'h500; MEPC = 32'h600;

    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
    checkOutput("rst_pc", PC, 32'h100);
    checkOutput("rst_ir", IR, 32'h0);
    checkOutput("rst_irv", {31'b0, IR_VALID}, 32'd0);
    checkOutput("rst_req", {31'b0, IMEM_REQ}, 32'd0);
    checkOutput("rst_mis", {31'b0, PC_MISALIGN}, 32'd0);

    // Boot: START cycle, then FETCH on the second cycle.
    RST = 1'b0;
    #1;
    checkOutput("boot_c1_req", {31'b0, IMEM_REQ}, 32'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
    checkOutput("boot_c2_req", {31'b0, IMEM_REQ}, 32'd1);
    checkOutput("boot_addr", IMEM_ADDR, 32'h100);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 32'h0000_0013);
    checkOutput("boot_ir", IR, 32'h13);
    checkOutput("boot_irv", {31'b0, IR_VALID}, 32'd1);
    checkOutput("boot_req_off", {31'b0, IMEM_REQ}, 32'd0);

    // Sequential flow with three wait cycles; a PC_WRITE mid-fetch is ignored.
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b0, 32'h0);
    checkOutput("seq_pc", PC, 32'h104);
    checkOutput("seq_irv", {31'b0, IR_VALID}, 32'd0);
    checkOutput("seq_w1_req", {31'b0, IMEM_REQ}, 32'd1);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
    checkOutput("seq_w2_req", {31'b0, IMEM_REQ}, 32'd1);
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 32'h0);
    checkOutput("fetch_wr_pc", PC, 32'h104);
    checkOutput("seq_w3_req", {31'b0, IMEM_REQ}, 32'd1);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
    checkOutput("seq_w4_req", {31'b0, IMEM_REQ}, 32'd1);
    checkOutput("seq_w4_addr", IMEM_ADDR, 32'h104);
    checkOutput("seq_w4_irv", {31'b0, IR_VALID}, 32'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 32'h0050_0093);
    checkOutput("seq_ir", IR, 32'h0050_0093);
    checkOutput("seq_req_off", {31'b0, IMEM_REQ}, 32'd0);

    // ACK while in HOLD must not touch IR.
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("hold_ack_ir", IR, 32'h0050_0093);
    checkOutput("hold_ack_irv", {31'b0, IR_VALID}, 32'd1);

    jumpAndFetch("src1", 3'd1, 32'h200);
    jumpAndFetch("src2", 3'd2, 32'h300);
    jumpAndFetch("src3", 3'd3, 32'h400);
    jumpAndFetch("src4", 3'd4, 32'h500);
    jumpAndFetch("src5", 3'd5, 32'h600);
    JALR = 32'h104;
    jumpAndFetch("src1b", 3'd1, 32'h104);
    jumpAndFetch("src7", 3'd7, 32'h108);

    // Misaligned jalr target is rejected with a one-cycle flag.
    JALR = 32'h202;
    applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 32'h0);
    checkOutput("mis_pc", PC, 32'h108);
    checkOutput("mis_flag", {31'b0, PC_MISALIGN}, 32'd1);
    checkOutput("mis_irv", {31'b0, IR_VALID}, 32'd1);
    checkOutput("mis_req", {31'b0, IMEM_REQ}, 32'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
    checkOutput("mis_flag_off", {31'b0, PC_MISALIGN}, 32'd0);
    jumpAndFetch("mis_trap", 3'd4, 32'h500);

    // Wrap of PC+4 at the top of the address space.
    MEPC = 32'hFFFF_FFFC;
    jumpAndFetch("wrap_load", 3'd5, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", PC_PLUS4, 32'h0);
    jumpAndFetch("wrap", 3'd0, 32'h0);
    checkOutput("wrap_mis", {31'b0, PC_MISALIGN}, 32'd0);

    // Reset in FETCH with a simultaneous ACK.
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b0, 32'h0);
    checkOutput("rf_req_pre", {31'b0, IMEM_REQ}, 32'd1);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 32'h1234_5678);
    checkOutput("rf_ir", IR, 32'h0);
    checkOutput("rf_irv", {31'b0, IR_VALID}, 32'd0);
    checkOutput("rf_pc", PC, 32'h100);
    checkOutput("rf_req", {31'b0, IMEM_REQ}, 32'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 32'h1234_5678);
    checkOutput("rf_late_ack_ir", IR, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
